// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_BLANK = 4'hF;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Largest value representable in the given number of decimal digits.
    function automatic longint unsigned max_dec(input int digits);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < digits; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: nibbles of 5 or more get +3 before the shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Bit-serial binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with leading-zero blanking and overflow indication for the 7-segment decoders.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_W     = 14,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [IN_W-1:0]           bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      overflow
);

    localparam int SCR_W = DIGIT_W * DIGITS;
    localparam int SR_W  = SCR_W + IN_W;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int LIM_W = IN_W + 1;

    localparam longint unsigned MAX_DEC = max_dec(DIGITS);
    localparam longint unsigned IN_MAX  = (64'd1 << IN_W) - 64'd1;
    // When every input fits in DIGITS decimal digits the overflow path folds away.
    localparam bit              OVF_EN  = (IN_MAX > MAX_DEC);
    localparam logic [LIM_W-1:0] LIMIT  = LIM_W'(OVF_EN ? MAX_DEC : IN_MAX);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(IN_W - 1);

    state_t             state;
    logic [SR_W-1:0]    sr;
    logic [SR_W-1:0]    sr_corr;
    logic [SR_W-1:0]    sr_next;
    logic [SCR_W-1:0]   scr_corr;
    logic [SCR_W-1:0]   scr_final;
    logic [SCR_W-1:0]   scr_shown;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pending;
    logic               in_ovf;
    logic               lead;

    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (sr[IN_W + d*DIGIT_W +: DIGIT_W]),
            .dout (scr_corr[d*DIGIT_W +: DIGIT_W])
        );
    end

    assign sr_corr   = {scr_corr, sr[IN_W-1:0]};
    assign sr_next   = sr_corr << 1;
    assign scr_final = sr_next[SR_W-1:IN_W];
    assign in_ovf    = OVF_EN && ({1'b0, bin_in} > LIMIT);

    // Blank zeros from the MSD down until the first nonzero digit; digit 0 always shows.
    always_comb begin
        scr_shown = scr_final;
        lead      = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (BLANK_LZ != 0 && lead && scr_final[d*DIGIT_W +: DIGIT_W] == '0) begin
                scr_shown[d*DIGIT_W +: DIGIT_W] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            bcd_out     <= {DIGITS{BCD_BLANK}};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr          <= {{SCR_W{1'b0}}, bin_in};
                        cnt         <= '0;
                        ovf_pending <= in_ovf;
                        busy        <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= sr_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        overflow <= ovf_pending;
                        bcd_out  <= ovf_pending ? {DIGITS{BCD_BLANK}} : scr_shown;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: blanking and non-blanking instances driven in lockstep.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] bin_in;
    logic        busy, done, overflow;
    logic [15:0] bcd_out;
    logic        busy0, done0, overflow0;
    logic [15:0] bcd_out0;

    int vectors;
    int miscompares;

    bin_to_bcd_seq #(.IN_W(14), .DIGITS(4), .BLANK_LZ(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
    );

    bin_to_bcd_seq #(.IN_W(14), .DIGITS(4), .BLANK_LZ(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy0), .done(done0), .bcd_out(bcd_out0), .overflow(overflow0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input int v, input bit blz);
        logic [15:0] r;
        int          t;
        bit          lead;
        if (v > 9999) return 16'hFFFF;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        if (blz) begin
            lead = 1'b1;
            for (int i = 3; i >= 1; i--) begin
                if (lead && r[i*4 +: 4] == 4'h0) r[i*4 +: 4] = 4'hF;
                else lead = 1'b0;
            end
        end
        return r;
    endfunction

    // Wait for done (bounded), counting cycles since the accept-edge cycle and busy cycles.
    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = 0;
        while (!done && n < 40) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_result(input string tag, input int v, input int n, input int bc);
        chk({tag, "_latency"}, n, 14);
        chk({tag, "_busycyc"}, bc, 14);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        chk({tag, "_bcd"}, bcd_out, model(v, 1'b1));
        chk({tag, "_ovf"}, overflow, (v > 9999));
        chk({tag, "_bcd_nolz"}, bcd_out0, model(v, 1'b0));
        chk({tag, "_ovf_nolz"}, overflow0, (v > 9999));
    endtask

    task automatic run(input int v, input string tag);
        int n, bc;
        @(negedge clk);
        bin_in = 14'(v);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 14'h2AAA;
        wait_done(n, bc);
        check_result(tag, v, n, bc);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int n, bc, extra, v, gap;
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_bcd", bcd_out, 16'hFFFF);
        chk("rst_bcd_nolz", bcd_out0, 16'hFFFF);
        rst_n = 1'b1;

        run(1234, "v1234");
        run(0, "v0");
        chk("v0_blank", bcd_out, 16'hFFF0);
        run(7, "v7");
        chk("v7_blank", bcd_out, 16'hFFF7);
        chk("v7_noblank", bcd_out0, 16'h0007);
        run(1005, "v1005");
        chk("v1005_inner_zeros", bcd_out, 16'h1005);
        run(9999, "v9999");
        run(10000, "v10000");
        run(16383, "v16383");

        // Reset mid-conversion aborts with no done.
        @(negedge clk);
        bin_in = 14'd5678;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_bcd", bcd_out, 16'hFFFF);
        chk("abort_ovf", overflow, 1'b0);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("abort_no_done", extra, 0);
        run(321, "v321");
        chk("v321_val", bcd_out, 16'hF321);

        // Start while busy is ignored; start held in the done cycle is accepted.
        @(negedge clk);
        bin_in = 14'd42;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n  = 0;
        bc = 0;
        while (!done && n < 40) begin
            if (busy) bc++;
            if (n == 5) begin
                bin_in = 14'd999;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check_result("busy_start", 42, n, bc);
        chk("busy_start_val", bcd_out, 16'hFF42);
        bin_in = 14'd999;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bin_in = '0;
        wait_done(n, bc);
        check_result("b2b", 999, n, bc);
        chk("b2b_val", bcd_out, 16'hF999);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("b2b_single_done", extra, 0);

        for (int i = 0; i < 40; i++) begin
            v   = int'($urandom_range(0, 16383));
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            run(v, $sformatf("rnd%0d_%0d", i, v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It is the stage directly upstream of the per-digit 7-segment decoders. It takes an unsigned binary value and produces DIGITS packed BCD nibbles. Blank digits are driven as 4'hF, which the downstream decoder renders as all segments off.

Parameters:
IN_W, 14, width of the binary input in bits.
DIGITS, 4, number of BCD output digits. Maximum representable value is 10^DIGITS-1.
BLANK_LZ, 1, when 1, leading-zero digits are replaced by 4'hF. The least-significant digit is never blanked.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
start  input  1  request a conversion; sampled only in IDLE.
bin_in  input  IN_W  unsigned binary value; captured on the edge where start is accepted.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse; bcd_out and overflow are valid and updated in this cycle.
bcd_out  output  4*DIGITS  packed BCD digits; digit 0 is in bits [3:0]. Held between conversions.
overflow  output  1  high when the last converted bin_in exceeded 10^DIGITS-1. Held with bcd_out.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, busy=0, done=0, overflow=0, bcd_out={DIGITS{4'hF}} (display blank).
- Reset mid-conversion aborts the conversion: no done pulse, and outputs return to their reset values.
- Reset has priority over all other inputs.
- States: IDLE and SHIFT (enum in package).
- IDLE, start=1 at an edge (the accept edge):
  - shift register = {BCD scratch of zeros, bin_in}
  - iteration counter = 0
  - ovf_pending = (bin_in > 10^DIGITS-1)
  - state -> SHIFT, busy=1
- IDLE, start=0: no action.
- SHIFT, each edge performs one iteration:
  - every scratch nibble >= 5 gets +3 (add3 stage);
  - the whole register is then shifted left by 1;
  - the counter increments.
- On the IN_W-th SHIFT edge (counter == IN_W-1):
  - the final iteration completes;
  - bcd_out, overflow and done=1 are registered on that same edge;
  - state -> IDLE, busy=0.
- Latency: done is high in the cycle that begins IN_W edges after the accept edge. busy is high for exactly IN_W cycles.
- Output formation, priority order:
  1. ovf_pending=1: bcd_out = all 4'hF, overflow=1.
  2. Otherwise, overflow=0. If BLANK_LZ=1, each zero digit with all higher digits also zero is set to 4'hF, scanning from the MSD down to digit 1. Digit 0 always shows its value, so 0 displays as a single "0".
  3. Zeros below a nonzero digit are never blanked; for example, 1005 gives 16'h1005.
- done is a single-cycle pulse and deasserts on the next edge.
- start while busy=1 is ignored, with no queuing; bin_in changes during SHIFT have no effect.
- start=1 in the cycle that done=1 is accepted (state is IDLE), so back-to-back conversions run with no bubble.
- Width rules:
  - the scratch register is 4*DIGITS bits;
  - add3 operates on 4-bit nibbles;
  - the counter is $clog2(IN_W+1) bits;
  - the 10^DIGITS-1 limit is an elaboration-time constant of width >= IN_W+1.
  - If 2^IN_W-1 <= 10^DIGITS-1, overflow is constant 0.

Decomposition:
- Package bcd_pkg:
  - DIGIT_W=4
  - BCD_BLANK=4'hF
  - state enum {IDLE, SHIFT}
  - function max_dec(DIGITS) returning 10^DIGITS-1
- Sub-module bcd_add3: a combinational 4-bit "if >=5 then +3" corrector, instantiated once per digit in a generate loop.
- Everything else lives in the top module.

Test Plan:
- bin_in=1234, start pulsed for 1 cycle -> busy high for 14 cycles; done pulse 14 cycles after accept; bcd_out=16'h1234, overflow=0.
- bin_in=0 with BLANK_LZ=1 -> bcd_out=16'hFFF0. bin_in=7 -> 16'hFFF7. bin_in=1005 -> 16'h1005. With BLANK_LZ=0, bin_in=7 -> 16'h0007.
- bin_in=9999 -> bcd_out=16'h9999, overflow=0. bin_in=10000 -> bcd_out=16'hFFFF, overflow=1. bin_in=16383 -> 16'hFFFF, overflow=1.
- Start 42, then pulse start with bin_in=999 at cycle 5 while busy -> the second start is ignored; done once with 16'hFF42. Then start=1 held in the done cycle with bin_in=999 -> accepted; next done gives 16'hF999.
- Start 5678, drive rst_n=0 at cycle 7 for 1 cycle -> no done; busy=0, bcd_out=16'hFFFF, overflow=0 after reset. A following start with 321 yields 16'hF321.
- Random sweep of 0..16383 with random start spacing -> each done matches the reference model, including blanking and overflow.
